seq_11011_gen: RTL and testbench
================================

SEQ_11011_GEN -- requirements
Module: seq_11011_gen

Interface
REQ-001 The module SHALL have parameter PATTERN, default 5'b11011, meaning the serial frame sent MSB first.
REQ-002 The module SHALL have parameter REPS_W, default 4, meaning the width of the repetition count.
REQ-003 The module SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port start  input  1  request to begin a burst, sampled in IDLE only.
REQ-006 The module SHALL have port reps  input  REPS_W  number of frames in the burst, captured with start.
REQ-007 The module SHALL have port overlap  input  1  1 = overlapped framing, 0 = back-to-back full frames, captured with start.
REQ-008 The module SHALL have port signal  output  1  serial data bit, registered.
REQ-009 The module SHALL have port valid  output  1  high in every cycle where signal carries a pattern bit, registered.
REQ-010 The module SHALL have port busy  output  1  high from the cycle after accepted start through the last bit.
REQ-011 The module SHALL have port done  output  1  one-cycle pulse in the cycle after the last bit.

Function
REQ-012 The module SHALL be a Moore FSM with states IDLE, B1, B2, B3, B4, B5, DONE, and all outputs SHALL be decoded from registered state only.
REQ-013 States B1..B5 SHALL drive signal = PATTERN[4..0] respectively with valid=1 and busy=1.
REQ-014 In IDLE and DONE, signal SHALL be 0 and valid 0; done=1 only in DONE.
REQ-015 In IDLE, start=1 with reps!=0 SHALL load reps and overlap into internal registers and go to B1 at the next edge; first bit appears one cycle after start.
REQ-016 In IDLE, start=1 with reps=0 SHALL be ignored: no transition, no done pulse.
REQ-017 start SHALL be ignored in every state other than IDLE; changes on reps/overlap during a burst SHALL have no effect.
REQ-018 From B5, if remaining frames > 1, the FSM SHALL go to B1 when overlap=0, or to B3 when overlap=1 (the trailing "11" serves as the next prefix); the remaining count decrements by 1.
REQ-019 From B5 with remaining = 1, the FSM SHALL go to DONE, then to IDLE unconditionally on the next edge.
REQ-020 Burst length SHALL be 5*reps bits when overlap=0 and 5+3*(reps-1) bits when overlap=1, emitted with no idle gaps.
REQ-021 Overlap reuse SHALL only be applied when PATTERN[4:3] == PATTERN[1:0]; otherwise overlap SHALL behave as 0 (always true for the default).
REQ-022 A start asserted in the DONE cycle SHALL be ignored; the earliest accepted restart is the cycle the FSM is back in IDLE.

Reset
REQ-023 When rst=0 at a rising clk edge, the state SHALL become IDLE, the repetition counter and captured overlap SHALL become 0, and signal, valid, busy, done SHALL all be 0 from the following cycle.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no done pulse; reset SHALL take priority over start.

Structure
REQ-025 State encoding localparams, the default PATTERN, and the frame length constant (5) SHALL live in a shared package, seq_11011_pkg, for reuse by the matching detector and benches.
REQ-026 The block SHALL be a single module with no sub-modules; the repetition down-counter is internal.

Verification
REQ-027 Reset then start=1, reps=1, overlap=0 -> signal 1,1,0,1,1 on 5 consecutive cycles with valid=1, then done=1 for exactly one cycle, then IDLE.
REQ-028 start, reps=3, overlap=0 -> 15-bit stream 110111101111011; the overlapping 11011 detector asserts out 3 times.
REQ-029 start, reps=3, overlap=1 -> 11-bit stream 11011011011; the overlapping detector asserts out 3 times; busy is high for exactly 11 cycles.
REQ-030 start, reps=0 -> busy, valid, done remain 0 for 10 cycles.
REQ-031 start, reps=2; pulse start again with reps=5 during B3 and in the DONE cycle -> exactly 10 bits then a single done pulse; second request ignored.
REQ-032 start, reps=4; drive rst=0 during B4 of frame 2 -> from the next cycle all outputs are 0 and there is no done pulse; a new start after rst=1 produces a full correct burst.

Source files
------------

// File: rtl/seq_11011_pkg.sv
// Shared constants for the 11011 serial frame generator and its detector.
// Holds the state encoding, default frame and frame length.
package seq_11011_pkg;

    localparam logic [4:0] DEFAULT_PATTERN = 5'b11011;
    localparam int         FRAME_LEN       = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B1   = 3'd1,
        S_B2   = 3'd2,
        S_B3   = 3'd3,
        S_B4   = 3'd4,
        S_B5   = 3'd5,
        S_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/seq_11011_gen.sv
// Burst generator that emits reps copies of a 5-bit frame, MSB first,
// optionally sharing the 2-bit suffix/prefix between consecutive frames.
module seq_11011_gen
    import seq_11011_pkg::*;
#(
    parameter logic [4:0] PATTERN = DEFAULT_PATTERN,
    parameter int         REPS_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REPS_W-1:0] reps,
    input  logic              overlap,
    output logic              signal,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    // Suffix must equal prefix for the trailing bits to start the next frame.
    localparam logic OVL_OK =
        (PATTERN[FRAME_LEN-1 -: 2] == PATTERN[1:0]);

    state_e            state_q, state_d;
    logic [REPS_W-1:0] cnt_q, cnt_d;
    logic              ovl_q, ovl_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (reps != '0)) begin
                    state_d = S_B1;
                    cnt_d   = reps;
                    ovl_d   = overlap & OVL_OK;
                end
            end
            S_B1: state_d = S_B2;
            S_B2: state_d = S_B3;
            S_B3: state_d = S_B4;
            S_B4: state_d = S_B5;
            S_B5: begin
                if (cnt_q > REPS_W'(1)) begin
                    cnt_d   = cnt_q - REPS_W'(1);
                    state_d = ovl_q ? S_B3 : S_B1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs, decoded from the state register only.
    always_comb begin
        signal = 1'b0;
        valid  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            S_B1: begin signal = PATTERN[4]; valid = 1'b1; busy = 1'b1; end
            S_B2: begin signal = PATTERN[3]; valid = 1'b1; busy = 1'b1; end
            S_B3: begin signal = PATTERN[2]; valid = 1'b1; busy = 1'b1; end
            S_B4: begin signal = PATTERN[1]; valid = 1'b1; busy = 1'b1; end
            S_B5: begin signal = PATTERN[0]; valid = 1'b1; busy = 1'b1; end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_11011_gen.sv
// Directed self-checking bench for seq_11011_gen.
// Expected streams are written out by hand per scenario.
module tb_seq_11011_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] reps = '0;
    logic       overlap = 1'b0;
    logic       signal, valid, busy, done;

    logic       start2 = 1'b0;
    logic [3:0] reps2 = '0;
    logic       overlap2 = 1'b0;
    logic       signal2, valid2, busy2, done2;

    int checks = 0;
    int failures = 0;

    seq_11011_gen #(.PATTERN(5'b11011), .REPS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .reps(reps),
        .overlap(overlap), .signal(signal), .valid(valid),
        .busy(busy), .done(done)
    );

    seq_11011_gen #(.PATTERN(5'b10011), .REPS_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .reps(reps2),
        .overlap(overlap2), .signal(signal2), .valid(valid2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        step();
        step();
        checks++;
        if (signal !== 1'b0) begin
            failures++;
            $display("FAIL reset_signal got=%b exp=0", signal);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic run_burst(input string nm, input logic [3:0] r,
                             input logic ov, input logic [31:0] exp,
                             input int n, input int exp_hits);
        int hits;
        int bcnt;
        logic [4:0] sh;
        hits = 0;
        bcnt = 0;
        sh = '0;
        start = 1'b1;
        reps = r;
        overlap = ov;
        step();
        start = 1'b0;
        reps = 4'd0;
        overlap = ~ov;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (signal !== exp[n-1-i] || valid !== 1'b1) begin
                failures++;
                $display("FAIL %s bit%0d signal=%b valid=%b exp=%b/1",
                         nm, i, signal, valid, exp[n-1-i]);
            end
            if (busy === 1'b1) bcnt++;
            if (valid === 1'b1) begin
                sh = {sh[3:0], signal};
                if (sh == 5'b11011) hits++;
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL %s end done=%b busy=%b valid=%b exp=1/0/0",
                     nm, done, busy, valid);
        end
        checks++;
        if (bcnt != n) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, bcnt, n);
        end
        checks++;
        if (hits != exp_hits) begin
            failures++;
            $display("FAIL %s detect got=%0d exp=%0d", nm, hits, exp_hits);
        end
        overlap = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle done=%b busy=%b exp=0/0", nm, done, busy);
        end
    endtask

    task automatic test_single();
        run_burst("single", 4'd1, 1'b0, 32'b11011, 5, 1);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b", 4'd3, 1'b0, 32'b110111101111011, 15, 3);
    endtask

    task automatic test_overlap();
        run_burst("ovl", 4'd3, 1'b1, 32'b11011011011, 11, 3);
    endtask

    task automatic test_zero_reps();
        start = 1'b1;
        reps = 4'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL zero_reps cyc%0d busy=%b valid=%b done=%b exp=0",
                         i, busy, valid, done);
            end
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_restart_ignored();
        logic [9:0] exp;
        exp = 10'b1101111011;
        start = 1'b1;
        reps = 4'd2;
        overlap = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (signal !== exp[9-i] || valid !== 1'b1) begin
                failures++;
                $display("FAIL restart bit%0d signal=%b valid=%b exp=%b/1",
                         i, signal, valid, exp[9-i]);
            end
            if (i == 2) begin
                start = 1'b1;
                reps = 4'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got=%b exp=1", done);
        end
        start = 1'b1;
        reps = 4'd5;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_idle done=%b busy=%b valid=%b exp=0",
                     done, busy, valid);
        end
        step();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_in_done busy=%b valid=%b exp=0", busy, valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [8:0] exp;
        exp = 9'b110111101;
        start = 1'b1;
        reps = 4'd4;
        overlap = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (signal !== exp[8-i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL rst_mid bit%0d signal=%b busy=%b exp=%b/1",
                         i, signal, busy, exp[8-i]);
            end
            if (i == 8) begin
                rst = 1'b0;
                start = 1'b1;
                reps = 4'd5;
            end
            step();
        end
        checks++;
        if (signal !== 1'b0 || valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_out sig=%b val=%b busy=%b done=%b exp=0",
                     signal, valid, busy, done);
        end
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_quiet cyc%0d done=%b valid=%b exp=0",
                         i, done, valid);
            end
        end
        rst = 1'b0;
        start = 1'b1;
        reps = 4'd3;
        step();
        rst = 1'b1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_prio busy=%b valid=%b exp=0", busy, valid);
        end
        step();
        run_burst("after_rst", 4'd2, 1'b1, 32'b11011011, 8, 2);
    endtask

    task automatic test_overlap_disallowed();
        logic [9:0] exp;
        int bcnt;
        exp = 10'b1001110011;
        bcnt = 0;
        start2 = 1'b1;
        reps2 = 4'd2;
        overlap2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (signal2 !== exp[9-i] || valid2 !== 1'b1) begin
                failures++;
                $display("FAIL no_ovl bit%0d signal=%b valid=%b exp=%b/1",
                         i, signal2, valid2, exp[9-i]);
            end
            if (busy2 === 1'b1) bcnt++;
            step();
        end
        checks++;
        if (done2 !== 1'b1 || bcnt != 10) begin
            failures++;
            $display("FAIL no_ovl_end done=%b busy_cycles=%0d exp=1/10",
                     done2, bcnt);
        end
        overlap2 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overlap();
        test_zero_reps();
        test_restart_ignored();
        test_reset_mid_burst();
        test_overlap_disallowed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
